// File: rtl/go_done_initiator_pkg.sv
// Shared definitions for the go/done handshake requester: state encoding,
// board defaults and the Moore output decode used by the FSM.
package go_done_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_CLK_HZ          = 32'd12000000;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd120000;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES  = 32'd36000000;

  typedef struct packed {
    logic go;
    logic busy;
    logic err;
  } outs_t;

  function automatic outs_t decode_outputs(input state_t s);
    outs_t o;
    o = '{go: 1'b0, busy: 1'b0, err: 1'b0};
    case (s)
      ST_IDLE: o = '{go: 1'b0, busy: 1'b0, err: 1'b0};
      ST_REQ:  o = '{go: 1'b1, busy: 1'b1, err: 1'b0};
      ST_ACK:  o = '{go: 1'b0, busy: 1'b1, err: 1'b0};
      ST_ERR:  o = '{go: 1'b0, busy: 1'b0, err: 1'b1};
      default: o = '{go: 1'b0, busy: 1'b0, err: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/go_done_initiator_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// press pulse on each debounced rising edge (release is silent).
module go_done_initiator_btn_debounce
  import go_done_initiator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level;

  // Synchronize, count consecutive mismatch cycles, flip level once stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/go_done_initiator.sv
// Requester end of the 4-phase go/done handshake: one go per debounced press,
// transaction count on the LEDs, timeout into a sticky error state.
module go_done_initiator
  import go_done_initiator_pkg::*;
#(
  parameter int unsigned CLK_HZ          = DEFAULT_CLK_HZ,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  input  logic             done_in,
  input  logic             err_clr,
  output logic             go_out,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] led
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 32'd1);

  if (CLK_HZ == 32'd0) begin : g_clk_hz_check
    $error("CLK_HZ must be non-zero");
  end

  logic          press;
  logic [1:0]    done_sync;
  logic          done_s;
  state_t        state;
  logic [TW-1:0] timer;

  assign done_s = done_sync[1];

  go_done_initiator_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_in),
    .press(press)
  );

  // done_in may come from an unrelated clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_sync <= 2'b00;
    end else begin
      done_sync <= {done_sync[0], done_in};
    end
  end

  // Handshake sequencing; outputs are registered alongside the state they decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= ST_IDLE;
      timer                 <= '0;
      led                   <= '0;
      {go_out, busy, err}   <= decode_outputs(ST_IDLE);
    end else begin
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (press && !done_s) begin
            state               <= ST_REQ;
            {go_out, busy, err} <= decode_outputs(ST_REQ);
          end else begin
            {go_out, busy, err} <= decode_outputs(ST_IDLE);
          end
        end
        ST_REQ: begin
          // done wins over a simultaneous timeout
          if (done_s) begin
            state               <= ST_ACK;
            timer               <= '0;
            led                 <= led + CNT_W'(1);
            {go_out, busy, err} <= decode_outputs(ST_ACK);
          end else if (timer == TIMER_LAST) begin
            state               <= ST_ERR;
            timer               <= '0;
            {go_out, busy, err} <= decode_outputs(ST_ERR);
          end else begin
            timer               <= timer + TW'(1);
            {go_out, busy, err} <= decode_outputs(ST_REQ);
          end
        end
        ST_ACK: begin
          if (!done_s) begin
            state               <= ST_IDLE;
            timer               <= '0;
            {go_out, busy, err} <= decode_outputs(ST_IDLE);
          end else if (timer == TIMER_LAST) begin
            state               <= ST_ERR;
            timer               <= '0;
            {go_out, busy, err} <= decode_outputs(ST_ERR);
          end else begin
            timer               <= timer + TW'(1);
            {go_out, busy, err} <= decode_outputs(ST_ACK);
          end
        end
        ST_ERR: begin
          timer <= '0;
          if (err_clr && !done_s) begin
            state               <= ST_IDLE;
            {go_out, busy, err} <= decode_outputs(ST_IDLE);
          end else begin
            {go_out, busy, err} <= decode_outputs(ST_ERR);
          end
        end
        default: begin
          state               <= ST_IDLE;
          timer               <= '0;
          {go_out, busy, err} <= decode_outputs(ST_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_go_done_initiator.sv
// Self-checking bench: random button/responder stimulus compared every cycle
// against a phase/elapsed-time reference model, plus directed corner cases.
module tb_go_done_initiator;

  localparam int DEB = 4;
  localparam int TO  = 50;
  localparam int CW  = 4;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          btn_in  = 1'b0;
  logic          done_in = 1'b0;
  logic          err_clr = 1'b0;
  logic          go_out;
  logic          busy;
  logic          err;
  logic [CW-1:0] led;

  int checks = 0;
  int errors = 0;

  int rdelay         = 2;
  int rcnt           = 0;
  bit resp_stuck     = 1'b0;
  bit resp_force     = 1'b0;
  bit resp_force_val = 1'b0;
  bit saw_go         = 1'b0;

  // reference model: phase 0 idle, 1 requesting, 2 acknowledging, 3 error
  bit m_btn_p, m_btn_s, m_level, m_press, m_done_p, m_done_s;
  int m_run, m_phase, m_entry, m_cyc, m_count;

  always #5 clk = ~clk;

  go_done_initiator #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_in),
    .done_in(done_in),
    .err_clr(err_clr),
    .go_out (go_out),
    .busy   (busy),
    .err    (err),
    .led    (led)
  );

  // Responder: follows go after rdelay+1 cycles, unless stuck or forced.
  always @(negedge clk) begin
    if (rst) begin
      done_in <= 1'b0;
      rcnt    <= 0;
    end else if (resp_force) begin
      done_in <= resp_force_val;
      rcnt    <= 0;
    end else if (resp_stuck) begin
      done_in <= 1'b0;
      rcnt    <= 0;
    end else if (go_out != done_in) begin
      if (rcnt >= rdelay) begin
        done_in <= go_out;
        rcnt    <= 0;
      end else begin
        rcnt <= rcnt + 1;
      end
    end else begin
      rcnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_btn_p = 1'b0; m_btn_s = 1'b0; m_level = 1'b0; m_press = 1'b0;
    m_done_p = 1'b0; m_done_s = 1'b0;
    m_run = 0; m_phase = 0; m_entry = 0; m_cyc = 0; m_count = 0;
  endtask

  task automatic model_enter(input int p);
    m_phase = p;
    m_entry = m_cyc;
  endtask

  task automatic model_step();
    bit np;
    m_cyc++;
    case (m_phase)
      0: if (m_press && !m_done_s) model_enter(1);
      1: begin
        if (m_done_s) begin
          model_enter(2);
          m_count = (m_count + 1) % (1 << CW);
        end else if (m_cyc - m_entry == TO) begin
          model_enter(3);
        end
      end
      2: begin
        if (!m_done_s) model_enter(0);
        else if (m_cyc - m_entry == TO) model_enter(3);
      end
      3: if (err_clr && !m_done_s) model_enter(0);
      default: model_enter(0);
    endcase
    np = 1'b0;
    if (m_btn_s != m_level) begin
      m_run++;
      if (m_run == DEB) begin
        m_level = m_btn_s;
        m_run   = 0;
        np      = m_level;
      end
    end else begin
      m_run = 0;
    end
    m_press  = np;
    m_done_s = m_done_p;
    m_done_p = done_in;
    m_btn_s  = m_btn_p;
    m_btn_p  = btn_in;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    #1;
    if (go_out === 1'b1) saw_go = 1'b1;
    check("go", go_out, 32'(m_phase == 1));
    check("busy", busy, 32'(m_phase == 1 || m_phase == 2));
    check("err", err, 32'(m_phase == 3));
    check("led", led, m_count);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press_btn(input int hold);
    btn_in = 1'b1;
    run(hold);
    btn_in = 1'b0;
    run(DEB + 4);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (n < budget && !(m_phase == 0 && done_in == 1'b0)) begin
      cycle();
      n++;
    end
    check("idle_reached", 32'(m_phase == 0 && done_in == 1'b0), 32'd1);
  endtask

  task automatic wait_go(input string tag);
    int n = 0;
    while (go_out !== 1'b1 && n < 60) begin
      cycle();
      n++;
    end
    check(tag, go_out, 32'd1);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int nb;
    model_reset();
    rst = 1'b1;
    run(3);
    check("rst_go", go_out, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_err", err, 32'd0);
    check("rst_led", led, 32'd0);
    rst = 1'b0;
    run(2);

    // clean press and done-rise to go-fall latency
    rdelay = 4;
    btn_in = 1'b1;
    wait_go("clean_go");
    n = 0;
    while (done_in !== 1'b1 && n < 20) begin cycle(); n++; end
    n = 0;
    while (go_out === 1'b1 && n < 10) begin cycle(); n++; end
    check("done_to_go_fall", n, 32'd3);
    btn_in = 1'b0;
    wait_idle(100);
    check("clean_led", led, 32'd1);
    check("clean_busy", busy, 32'd0);

    // bouncing button yields exactly one transaction
    for (int i = 0; i < 12; i++) begin
      btn_in = ((i / 2) % 2 == 0);
      cycle();
    end
    btn_in = 1'b1;
    run(10);
    btn_in = 1'b0;
    wait_idle(100);
    check("bounce_led", led, 32'd2);

    // timeout from REQ
    resp_stuck = 1'b1;
    btn_in = 1'b1;
    wait_go("timeout_go_seen");
    btn_in = 1'b0;
    n = 0;
    while (err !== 1'b1 && n < 100) begin cycle(); n++; end
    check("timeout_cycles", n, 32'd50);
    check("timeout_go", go_out, 32'd0);
    check("timeout_led", led, 32'd2);
    resp_stuck = 1'b0;
    run(3);
    pulse_clr();
    check("clr_err", err, 32'd0);
    check("clr_busy", busy, 32'd0);

    // stale done: press dropped, and err_clr ignored while done is high
    resp_force = 1'b1;
    resp_force_val = 1'b1;
    run(4);
    saw_go = 1'b0;
    press_btn(8);
    run(5);
    check("stale_no_go", 32'(saw_go), 32'd0);
    check("stale_busy", busy, 32'd0);
    resp_force = 1'b0;
    wait_idle(50);
    run(3);
    resp_stuck = 1'b1;
    press_btn(6);
    n = 0;
    while (err !== 1'b1 && n < 100) begin cycle(); n++; end
    check("stale_err_entry", err, 32'd1);
    resp_stuck = 1'b0;
    resp_force = 1'b1;
    run(4);
    pulse_clr();
    run(2);
    check("stale_clr_ignored", err, 32'd1);
    resp_force = 1'b0;
    run(10);
    pulse_clr();
    check("late_clr", err, 32'd0);

    // sixteen transactions wrap the counter back
    for (int k = 0; k < 16; k++) begin
      rdelay = $urandom_range(0, 5);
      press_btn($urandom_range(5, 10));
      wait_idle(200);
    end
    check("wrap_led", led, 32'd2);

    // second press during a slow REQ is discarded
    rdelay = 40;
    btn_in = 1'b1;
    wait_go("discard_go");
    btn_in = 1'b0;
    run(8);
    btn_in = 1'b1;
    run(8);
    btn_in = 1'b0;
    check("discard_still_req", go_out, 32'd1);
    wait_idle(200);
    run(20);
    check("discard_led", led, 32'd3);
    check("discard_no_extra", busy, 32'd0);

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      rdelay = $urandom_range(0, 6);
      resp_stuck = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) begin
        nb = $urandom_range(2, 10);
        for (int i = 0; i < nb; i++) begin
          btn_in = 1'($urandom_range(0, 1));
          cycle();
        end
      end
      press_btn($urandom_range(2, 12));
      if ($urandom_range(0, 2) == 0) press_btn(6);
      if ($urandom_range(0, 4) == 0) pulse_clr();
      if (resp_stuck) begin
        run(TO + 5);
        resp_stuck = 1'b0;
        run(4);
        pulse_clr();
      end
      wait_idle(300);
    end

    // asynchronous reset in the middle of REQ
    resp_stuck = 1'b1;
    btn_in = 1'b1;
    wait_go("mid_go");
    rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_go", go_out, 32'd0);
    check("mid_rst_led", led, 32'd0);
    check("mid_rst_busy", busy, 32'd0);
    btn_in = 1'b0;
    resp_stuck = 1'b0;
    run(2);
    rst = 1'b0;
    run(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
